// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
// Accepts one execute bundle per cycle. Non-memory results and misaligned
// accesses pass straight to the registered writeback bundle. Aligned
// loads and stores issue a single request on the data bus and hold the
// upstream pipeline until the response arrives.
module memory_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned REGADDR = 5
) (
    input  logic               clk,
    input  logic               reset,
    // execute bundle
    input  logic               in_en,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic [1:0]         in_msize,
    input  logic               in_unsigned,
    input  logic [XLEN-1:0]    in_addr,
    input  logic [XLEN-1:0]    in_wdata,
    input  logic [REGADDR-1:0] in_dst,
    input  logic               in_wb_en,
    input  logic [XLEN-1:0]    in_pc,
    output logic               in_ready,
    // data bus
    output logic               dreq_valid,
    output logic [XLEN-1:0]    dreq_addr,
    output logic [7:0]         dreq_strobe,
    output logic [XLEN-1:0]    dreq_wdata,
    input  logic               dresp_data_ok,
    input  logic [XLEN-1:0]    dresp_data,
    // writeback bundle
    input  logic               out_ready,
    output logic               out_en,
    output logic [XLEN-1:0]    out_result,
    output logic [REGADDR-1:0] out_dst,
    output logic               out_wb_en,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_misaligned
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_t;

    state_t               state;

    // Attributes of the outstanding access, needed to shape the response
    logic [2:0]           req_off;
    size_t                req_size;
    logic                 req_unsigned;
    logic                 req_store;
    logic [REGADDR-1:0]   req_dst;
    logic                 req_wb_en;
    logic [XLEN-1:0]      req_pc;

    logic                 slot_free;
    logic                 is_mem;
    logic                 misaligned;
    logic [2:0]           off;
    size_t                size;
    logic [7:0]           size_mask;
    logic [XLEN-1:0]      shifted;
    logic [XLEN-1:0]      load_value;

    // Handshake: ready only with no access outstanding and a free output slot
    always_comb begin
        slot_free = !out_en || out_ready;
        in_ready  = (state == ST_IDLE) && slot_free;
    end

    // Decode of the incoming bundle: access size, lane offset, alignment
    always_comb begin
        is_mem    = in_mem_read || in_mem_write;
        off       = in_addr[2:0];
        size      = size_t'(in_msize);
        size_mask = 8'h00;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                size_mask  = 8'h01;
                misaligned = 1'b0;
            end
            SZ_HALF: begin
                size_mask  = 8'h03;
                misaligned = off[0];
            end
            SZ_WORD: begin
                size_mask  = 8'h0F;
                misaligned = |off[1:0];
            end
            SZ_DWORD: begin
                size_mask  = 8'hFF;
                misaligned = |off;
            end
            default: begin
                size_mask  = 8'h00;
                misaligned = 1'b0;
            end
        endcase
    end

    // Load data: move the addressed lane to bit 0, then truncate and extend
    always_comb begin
        shifted    = dresp_data >> {req_off, 3'b000};
        load_value = shifted;
        case (req_size)
            SZ_BYTE: load_value = req_unsigned
                ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_value = req_unsigned
                ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_value = req_unsigned
                ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            SZ_DWORD: load_value = shifted;
            default:  load_value = shifted;
        endcase
    end

    // Stage control: accept bundles, run the bus request, fill the output slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            req_off        <= '0;
            req_size       <= SZ_BYTE;
            req_unsigned   <= 1'b0;
            req_store      <= 1'b0;
            req_dst        <= '0;
            req_wb_en      <= 1'b0;
            req_pc         <= '0;
            dreq_valid     <= 1'b0;
            dreq_addr      <= '0;
            dreq_strobe    <= '0;
            dreq_wdata     <= '0;
            out_en         <= 1'b0;
            out_result     <= '0;
            out_dst        <= '0;
            out_wb_en      <= 1'b0;
            out_pc         <= '0;
            out_misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A stalled output slot freezes everything, including the bundle
                    if (slot_free) begin
                        if (!in_en) begin
                            out_en <= 1'b0;
                        end else if (!is_mem) begin
                            out_en         <= 1'b1;
                            out_result     <= in_addr;
                            out_dst        <= in_dst;
                            out_wb_en      <= in_wb_en;
                            out_pc         <= in_pc;
                            out_misaligned <= 1'b0;
                        end else if (misaligned) begin
                            out_en         <= 1'b1;
                            out_result     <= '0;
                            out_dst        <= in_dst;
                            out_wb_en      <= 1'b0;
                            out_pc         <= in_pc;
                            out_misaligned <= 1'b1;
                        end else begin
                            out_en       <= 1'b0;
                            state        <= ST_WAIT;
                            dreq_valid   <= 1'b1;
                            dreq_addr    <= {in_addr[XLEN-1:3], 3'b000};
                            dreq_strobe  <= in_mem_write ? (size_mask << off) : 8'h00;
                            dreq_wdata   <= in_wdata << {off, 3'b000};
                            req_off      <= off;
                            req_size     <= size;
                            req_unsigned <= in_unsigned;
                            req_store    <= in_mem_write;
                            req_dst      <= in_dst;
                            req_wb_en    <= in_wb_en;
                            req_pc       <= in_pc;
                        end
                    end
                end
                ST_WAIT: begin
                    // The output slot is always empty here: it was cleared on issue
                    if (dresp_data_ok) begin
                        state          <= ST_IDLE;
                        dreq_valid     <= 1'b0;
                        out_en         <= 1'b1;
                        out_result     <= req_store ? '0 : load_value;
                        out_dst        <= req_dst;
                        out_wb_en      <= req_store ? 1'b0 : req_wb_en;
                        out_pc         <= req_pc;
                        out_misaligned <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
